// File: rtl/gem_frame_tx.sv
// gem_frame_tx
//   Packs a (32*NWORDS-8)-bit GEM cluster payload into NWORDS consecutive
//   32-bit GTX TX words, closing each frame with a K-code byte (bunch marker,
//   latency marker DC or overflow FC). Sends comma idle fill while the link is
//   not ready. Has a PRBS-31 test payload mode with single-bit error injection.
//
// Ports
//   TRG_CLK80    TX user clock 2 (sole clock)
//   TRG_RST      synchronous active-high reset
//   GEM_DATA     frame payload, sampled at frame start
//   GEM_OVERFLOW S-bit overflow, sampled at frame start
//   TX_READY     link ready; low -> idle fill after the current frame
//   ENA_TEST_PAT PRBS payload select, sampled at frame start
//   INJ_ERR      pulse: invert bit 31 of word 0 of the next test-mode frame
//   TX_DATA      GTX TXDATA (registered)
//   TX_ISK       GTX TXCHARISK (registered)
//   WORD_SEL     index of the word on TX_DATA
//   FRAME_START  word 0 is on TX_DATA
//   LTNCY_TRIG   last word of a latency-marker frame is on TX_DATA
//   FRAME_CNT    frames sent, wraps
//   OVF_CNT      overflow frames sent, saturates
module gem_frame_tx #(
  parameter int          NWORDS       = 2,
  parameter int          LTNCY_PERIOD = 256,
  parameter logic [30:0] PRBS_SEED    = 31'h7FFFFFFF,
  localparam int         PW           = 32*NWORDS-8,
  localparam int         WSW          = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic           TRG_CLK80,
  input  logic           TRG_RST,
  input  logic [PW-1:0]  GEM_DATA,
  input  logic           GEM_OVERFLOW,
  input  logic           TX_READY,
  input  logic           ENA_TEST_PAT,
  input  logic           INJ_ERR,
  output logic [31:0]    TX_DATA,
  output logic [3:0]     TX_ISK,
  output logic [WSW-1:0] WORD_SEL,
  output logic           FRAME_START,
  output logic           LTNCY_TRIG,
  output logic [15:0]    FRAME_CNT,
  output logic [15:0]    OVF_CNT
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WSW-1:0] WLAST     = WSW'(NWORDS-1);
  localparam logic [15:0]    LT_MASK   = 16'(LTNCY_PERIOD-1);
  localparam logic [31:0]    IDLE_WORD = 32'h50BC50BC;
  localparam logic [7:0]     K_OVF     = 8'hFC;
  localparam logic [7:0]     K_LAT     = 8'hDC;

  state_t                  state_q, state_n;
  logic [WSW-1:0]          w_q, wn, widx;
  logic [1:0]              bseq_q;
  logic [PW-1:0]           pay_q, pl;
  logic [7:0]              k_q, kx, kb_n;
  logic                    tst_q, tst_n, inj_q, inj_eff;
  logic                    start, load, last_n;
  logic [30:0]             lfsr_q, lfsr_base, lfsr_adv;
  logic [31:0]             prbs_w, data_n;
  logic [NWORDS-1:0][31:0] fw;

  // 32 steps of x^31+x^28+1; first generated bit lands in the word MSB.
  function automatic logic [62:0] prbs_step(input logic [30:0] s);
    logic [30:0] st;
    logic [31:0] d;
    st = s;
    d  = '0;
    for (int i = 0; i < 32; i++) begin
      d  = {d[30:0], st[30] ^ st[27]};
      st = {st[29:0], st[30] ^ st[27]};
    end
    return {st, d};
  endfunction

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (TX_READY) state_n = RUN;
      RUN:     if (w_q == WLAST && !TX_READY) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Frame control: a new frame starts only on a frame boundary with the link ready.
  always_comb begin
    start  = TX_READY && (state_q == IDLE || w_q == WLAST);
    load   = start || (state_q == RUN && w_q != WLAST);
    wn     = start ? '0 : w_q + 1'b1;
    last_n = (wn == WLAST);
    pl     = start ? GEM_DATA : pay_q;
    tst_n  = start ? ENA_TEST_PAT : tst_q;
    case (bseq_q)
      2'd0: kx = 8'hBC;
      2'd1: kx = 8'hF7;
      2'd2: kx = 8'hFB;
      default: kx = 8'hFD;
    endcase
    if (GEM_OVERFLOW)                       kx = K_OVF;
    else if ((FRAME_CNT & LT_MASK) == 16'd0) kx = K_LAT;
    kb_n    = start ? kx : k_q;
    inj_eff = start && ENA_TEST_PAT && (inj_q || INJ_ERR);
    // Restart the PRBS from the seed whenever the stream is (re)entered.
    lfsr_base = (state_q == IDLE || (start && ENA_TEST_PAT && !tst_q)) ? PRBS_SEED : lfsr_q;
  end

  // {payload, K} is exactly NWORDS words, most significant word first.
  assign fw = {pl, kb_n};

  always_comb begin
    {lfsr_adv, prbs_w} = prbs_step(lfsr_base);
    widx = WLAST - wn;
    if (tst_n) begin
      data_n = last_n ? {prbs_w[23:0], kb_n} : prbs_w;
      if (inj_eff) data_n[31] = ~data_n[31];
    end else begin
      data_n = fw[widx];
    end
  end

  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST) begin
      state_q     <= IDLE;
      w_q         <= '0;
      bseq_q      <= '0;
      pay_q       <= '0;
      k_q         <= '0;
      tst_q       <= 1'b0;
      inj_q       <= 1'b0;
      lfsr_q      <= PRBS_SEED;
      TX_DATA     <= IDLE_WORD;
      TX_ISK      <= 4'b0101;
      WORD_SEL    <= '0;
      FRAME_START <= 1'b0;
      LTNCY_TRIG  <= 1'b0;
      FRAME_CNT   <= '0;
      OVF_CNT     <= '0;
    end else begin
      state_q <= state_n;
      inj_q   <= start ? 1'b0 : (inj_q | INJ_ERR);
      if (start) begin
        pay_q  <= GEM_DATA;
        k_q    <= kx;
        tst_q  <= ENA_TEST_PAT;
        bseq_q <= bseq_q + 2'd1;
      end
      if (load) begin
        w_q         <= wn;
        lfsr_q      <= lfsr_adv;
        TX_DATA     <= data_n;
        TX_ISK      <= last_n ? 4'b0001 : 4'b0000;
        WORD_SEL    <= wn;
        FRAME_START <= start;
        LTNCY_TRIG  <= last_n && (kb_n == K_LAT);
        if (last_n) begin
          FRAME_CNT <= FRAME_CNT + 16'd1;
          if (kb_n == K_OVF && OVF_CNT != 16'hFFFF) OVF_CNT <= OVF_CNT + 16'd1;
        end
      end else begin
        w_q         <= '0;
        lfsr_q      <= PRBS_SEED;
        TX_DATA     <= IDLE_WORD;
        TX_ISK      <= 4'b0101;
        WORD_SEL    <= '0;
        FRAME_START <= 1'b0;
        LTNCY_TRIG  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gem_frame_tx.sv
module tb_gem_frame_tx;

  localparam logic [30:0] SEED = 31'h7FFFFFFF;
  localparam logic [31:0] IDLE_W = 32'h50BC50BC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NWORDS=2 instance
  logic         rst, rdy, ovf, tst, inj;
  logic [55:0]  d2;
  logic [31:0]  txd2;
  logic [3:0]   isk2;
  logic [0:0]   ws2;
  logic         fs2, lt2;
  logic [15:0]  fc2, oc2;

  // NWORDS=4 instance
  logic         rst4, rdy4;
  logic         ovf4 = 1'b0, tst4 = 1'b0, inj4 = 1'b0;
  logic [119:0] d4;
  logic [31:0]  txd4;
  logic [3:0]   isk4;
  logic [1:0]   ws4;
  logic         fs4, lt4;
  logic [15:0]  fc4, oc4;

  gem_frame_tx #(.NWORDS(2)) dut (
    .TRG_CLK80(clk), .TRG_RST(rst), .GEM_DATA(d2), .GEM_OVERFLOW(ovf),
    .TX_READY(rdy), .ENA_TEST_PAT(tst), .INJ_ERR(inj),
    .TX_DATA(txd2), .TX_ISK(isk2), .WORD_SEL(ws2), .FRAME_START(fs2),
    .LTNCY_TRIG(lt2), .FRAME_CNT(fc2), .OVF_CNT(oc2));

  gem_frame_tx #(.NWORDS(4)) dut4 (
    .TRG_CLK80(clk), .TRG_RST(rst4), .GEM_DATA(d4), .GEM_OVERFLOW(ovf4),
    .TX_READY(rdy4), .ENA_TEST_PAT(tst4), .INJ_ERR(inj4),
    .TX_DATA(txd4), .TX_ISK(isk4), .WORD_SEL(ws4), .FRAME_START(fs4),
    .LTNCY_TRIG(lt4), .FRAME_CNT(fc4), .OVF_CNT(oc4));

  typedef struct {
    int          cyc;
    int          inst;
    logic [31:0] d;
    logic [3:0]  k;
    int          ws;
    logic        fs;
    logic        lt;
    logic        ce;
    logic [15:0] fc;
    logic [15:0] oc;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   ecnt = 0;
  int   nchk = 0;
  int   nerr = 0;
  logic done = 1'b0;

  // bench model state
  logic [15:0] exp_fc, exp_oc, exp_fc4;
  logic [1:0]  tb_bseq;
  logic        tb_inj, tb_from_idle, tb_tst_prev;
  logic [30:0] m;
  logic [7:0]  ktab [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};

  initial forever begin
    @(posedge clk);
    ecnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // expectation for the outputs right after the next active edge
  task automatic push(input int inst, input logic [31:0] d, input logic [3:0] k,
                      input int ws, input logic fs, input logic lt, input logic ce,
                      input logic [15:0] fc, input logic [15:0] oc, input string nm);
    exp_t e;
    e.cyc = ecnt + 1; e.inst = inst; e.d = d; e.k = k; e.ws = ws; e.fs = fs;
    e.lt = lt; e.ce = ce; e.fc = fc; e.oc = oc; e.nm = nm;
    q.push_back(e);
  endtask

  // reference PRBS-31 (x^31+x^28+1), 32 bits, first bit in the MSB
  task automatic next_word(output logic [31:0] wd);
    logic nb;
    wd = '0;
    for (int i = 0; i < 32; i++) begin
      nb = m[30] ^ m[27];
      m  = {m[29:0], nb};
      wd = {wd[30:0], nb};
    end
  endtask

  function automatic logic [55:0] pat(input int i);
    return {8'(i), 8'(i*3), 8'hA5, 8'(~i), 8'h5A, 8'(i*7), 8'hC3};
  endfunction

  // one NWORDS=2 frame; r1 is TX_READY during the word-1 edge
  task automatic send2(input logic [55:0] d, input logic o, input logic t,
                       input logic i0, input logic i1, input logic r1, input string nm);
    logic [7:0]  kx;
    logic [31:0] w0, w1, pw;
    logic        eff;
    kx = o ? 8'hFC : ((exp_fc[7:0] == 8'h00) ? 8'hDC : ktab[tb_bseq]);
    tb_bseq = tb_bseq + 2'd1;
    if (t && (tb_from_idle || !tb_tst_prev)) m = SEED;
    tb_inj = tb_inj | i0;
    eff    = tb_inj & t;
    tb_inj = 1'b0;
    if (t) begin
      next_word(pw);
      w0 = pw ^ {eff, 31'd0};
    end else begin
      w0 = d[55:24];
    end
    d2 = d; ovf = o; tst = t; inj = i0; rdy = 1'b1;
    push(0, w0, 4'b0000, 0, 1'b1, 1'b0, 1'b1, exp_fc, exp_oc, nm);
    tick();
    if (t) begin
      next_word(pw);
      w1 = {pw[23:0], kx};
    end else begin
      w1 = {d[23:0], kx};
    end
    exp_fc = exp_fc + 16'd1;
    if (kx == 8'hFC && exp_oc != 16'hFFFF) exp_oc = exp_oc + 16'd1;
    // frame inputs change mid-frame: the captured copy must be used
    d2 = ~d; ovf = ~o; tst = ~t; inj = i1; rdy = r1;
    tb_inj = tb_inj | i1;
    push(0, w1, 4'b0001, 1, 1'b0, (kx == 8'hDC), 1'b1, exp_fc, exp_oc, nm);
    tick();
    inj = 1'b0;
    tb_tst_prev = t;
    tb_from_idle = 1'b0;
  endtask

  task automatic send4(input logic [119:0] d, input logic [7:0] kx, input string nm);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      d4   = (k == 0) ? d : ~d;
      rdy4 = 1'b1;
      w    = (k == 3) ? {d[23:0], kx} : d[119-32*k -: 32];
      if (k == 3) exp_fc4 = exp_fc4 + 16'd1;
      push(1, w, (k == 3) ? 4'b0001 : 4'b0000, k, (k == 0), (k == 3 && kx == 8'hDC),
           1'b1, exp_fc4, 16'd0, nm);
      tick();
    end
  endtask

  // stimulus
  initial begin
    rst = 1'b1; rdy = 1'b0; d2 = '0; ovf = 1'b0; tst = 1'b0; inj = 1'b0;
    rst4 = 1'b1; rdy4 = 1'b0; d4 = '0;
    exp_fc = '0; exp_oc = '0; exp_fc4 = '0; tb_bseq = '0; tb_inj = 1'b0;
    tb_from_idle = 1'b1; tb_tst_prev = 1'b0; m = SEED;
    tick();
    push(0, IDLE_W, 4'b0101, 0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, "reset");
    tick();
    rst = 1'b0; rst4 = 1'b0;

    // first frame is a latency marker, then the bunch sequence
    send2(56'h0123456789ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "first_frame");
    for (int i = 1; i < 9; i++) send2(pat(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bseq");
    for (int i = 9; i < 256; i++) send2(pat(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "run");

    // overflow beats the latency marker at FRAME_CNT=256
    send2(pat(256), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "ovf_at_256");
    send2(pat(257), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "post_ovf");
    for (int i = 0; i < 300; i++) send2(pat(i + 300), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "ovf_run");
    send2(pat(7), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "post_ovf_run");

    // TX_READY drops after word 0: word 1 still goes, then idle fill
    send2(pat(11), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rdy_drop");
    for (int i = 0; i < 3; i++) begin
      push(0, IDLE_W, 4'b0101, 0, 1'b0, 1'b0, 1'b1, exp_fc, exp_oc, "idle_fill");
      tick();
    end
    tb_from_idle = 1'b1;
    send2(pat(12), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rdy_back");

    // PRBS test mode with error injection
    send2(pat(20), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "prbs_first");
    send2(pat(21), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "prbs_pulse");
    send2(pat(22), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "prbs_inj_next");
    send2(pat(23), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "prbs_inj_on_start");
    send2(pat(24), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "prbs_pulse2");
    send2(pat(25), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "plain_drops_inj");
    send2(pat(26), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "prbs_reload");

    // reset on word 1: frame abandoned, counters cleared
    d2 = pat(30); ovf = 1'b0; tst = 1'b0; rdy = 1'b1;
    push(0, d2[55:24], 4'b0000, 0, 1'b1, 1'b0, 1'b1, exp_fc, exp_oc, "pre_rst_w0");
    tick();
    rst = 1'b1;
    push(0, IDLE_W, 4'b0101, 0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, "mid_frame_rst");
    tick();
    rst = 1'b0;
    exp_fc = '0; exp_oc = '0; tb_bseq = '0; tb_inj = 1'b0;
    tb_from_idle = 1'b1; tb_tst_prev = 1'b0;
    send2(pat(31), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "after_rst");
    send2(pat(32), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "after_rst2");

    // four-word frames
    send4(120'h00112233445566778899AABBCCDDEE, 8'hDC, "n4_f0");
    send4(120'hF0E1D2C3B4A5968778695A4B3C2D1E, 8'hF7, "n4_f1");
    rdy4 = 1'b0;
    push(1, IDLE_W, 4'b0101, 0, 1'b0, 1'b0, 1'b1, exp_fc4, 16'd0, "n4_idle");
    tick();
    tick();
    tick();
    done = 1'b1;
  end

  // monitor / scoreboard
  initial begin
    exp_t        e;
    logic [31:0] ad;
    logic [3:0]  ak;
    int          aws;
    logic        afs, alt, bad;
    logic [15:0] afc, aoc;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= ecnt) begin
        e = q.pop_front();
        if (e.inst == 0) begin
          ad = txd2; ak = isk2; aws = int'(ws2); afs = fs2; alt = lt2; afc = fc2; aoc = oc2;
        end else begin
          ad = txd4; ak = isk4; aws = int'(ws4); afs = fs4; alt = lt4; afc = fc4; aoc = oc4;
        end
        bad = (e.cyc != ecnt) || (ad !== e.d) || (ak !== e.k) || (aws != e.ws) ||
              (afs !== e.fs) || (alt !== e.lt) ||
              (e.ce && ((afc !== e.fc) || (aoc !== e.oc)));
        nchk++;
        if (bad) begin
          nerr++;
          $display("FAIL %s cyc=%0d/%0d got d=%h isk=%b ws=%0d fs=%b lt=%b fc=%0d oc=%0d want d=%h isk=%b ws=%0d fs=%b lt=%b fc=%0d oc=%0d",
                   e.nm, ecnt, e.cyc, ad, ak, aws, afs, alt, afc, aoc,
                   e.d, e.k, e.ws, e.fs, e.lt, e.fc, e.oc);
        end
      end
      if (done) begin
        nchk++;
        if (q.size() != 0) begin
          nerr++;
          $display("FAIL leftover_expectations got %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want summary (compared %0d)", nchk);
    $fatal(1, "timeout");
  end

endmodule
